// File: rtl/serial_add_pkg.sv
// Shared types and constants for the 2-bit-per-cycle arbitrated serial adder.
package serial_add_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/serial_add_arb_if.sv
// Requester, status and result signals of the serial adder, bundled for port hookup.
interface serial_add_arb_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin0;
  logic             cin1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_id;

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1, out_ready,
    input  ack0, ack1, busy, out_valid, out_sum, out_carry, out_id
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1, out_ready,
    output ack0, ack1, busy, out_valid, out_sum, out_carry, out_id
  );

endinterface

// File: rtl/add2_slice.sv
// Combinational 2-bit adder slice with carry-in and carry-out.
module add2_slice
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_add_arb.sv
// Two-requester round-robin arbiter feeding a serial adder that retires 2 bits per cycle.
module serial_add_arb
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_arb_if.slave bus
);

  localparam int unsigned NumSlices = WIDTH / SLICE_W;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             owner_q, owner_d, id_q, id_d, last_q, last_d;
  logic             accept, grant;
  logic [SLICE_W-1:0] slice_sum;
  logic             slice_cout;

  // Operands shift right each RUN cycle, so the slice always sees the next pair in bits [1:0].
  add2_slice u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign accept = (state_q == IDLE) && (bus.req0 || bus.req1);
  assign grant  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    owner_d = owner_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = grant ? bus.a1 : bus.a0;
          b_d     = grant ? bus.b1 : bus.b0;
          carry_d = grant ? bus.cin1 : bus.cin0;
          owner_d = grant;
          last_d  = grant;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = slice_cout;
        acc_d   = acc_q >> SLICE_W;
        acc_d[WIDTH-1 -: SLICE_W] = slice_sum;
        cnt_d   = cnt_q + 1'b1;
        // Result registers only move here, so they hold their old value outside DONE.
        if (cnt_q == LastCnt) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = slice_cout;
          id_d    = owner_q;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      owner_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;  // pretend requester 1 went last so requester 0 wins the first tie
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Acks are combinational off the request, so gate them with reset to keep them low at once.
  assign bus.ack0      = rst_n & accept & ~grant;
  assign bus.ack1      = rst_n & accept & grant;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = cout_q;
  assign bus.out_id    = id_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed bench for serial_add_arb: scoreboard of expected results checked at each handshake.
module tb_serial_add_arb;
  import serial_add_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  serial_add_arb_if #(.WIDTH(WIDTH)) bus ();

  serial_add_arb #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             id;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a, b, input logic cin);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    model.sum   = t[WIDTH-1:0];
    model.carry = t[WIDTH];
    model.id    = id;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic [WIDTH-1:0] a, b, input logic cin);
    if (id) begin
      bus.a1 = a; bus.b1 = b; bus.cin1 = cin; bus.req1 = 1'b1;
    end else begin
      bus.a0 = a; bus.b0 = b; bus.cin0 = cin; bus.req0 = 1'b1;
    end
  endtask

  task automatic drop(input logic id);
    if (id) bus.req1 = 1'b0;
    else    bus.req0 = 1'b0;
  endtask

  // Called right after driving at a falling edge; returns at the sample point of the ack cycle.
  task automatic wait_ack(input logic id);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if ((id ? bus.ack1 : bus.ack0) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(id ? "ack1_seen" : "ack0_seen", {31'b0, got}, 32'd1);
  endtask

  // Called at the falling edge of cycle T+1; expects out_valid in cycle T+WIDTH/2+1.
  task automatic wait_result(input exp_t e, input bit hs);
    int lat;
    lat = 1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.out_valid === 1'b1) break;
      check("sum_hold", {24'b0, bus.out_sum}, {24'b0, last_exp.sum});
      check("carry_hold", {31'b0, bus.out_carry}, {31'b0, last_exp.carry});
      @(negedge clk);
      lat++;
    end
    check("latency", lat, WIDTH / 2 + 1);
    last_exp = e;
    if (hs) begin
      @(negedge clk);
      #1;
      check("valid_drop", {31'b0, bus.out_valid}, 32'd0);
      check("busy_idle", {31'b0, bus.busy}, 32'd0);
    end
  endtask

  task automatic run_op(input logic id, input logic [WIDTH-1:0] a, b, input logic cin);
    exp_t e;
    @(negedge clk);
    set_req(id, a, b, cin);
    e = model(id, a, b, cin);
    sb.push_back(e);
    wait_ack(id);
    @(negedge clk);
    drop(id);
    wait_result(e, 1'b1);
  endtask

  task automatic both(input logic first);
    exp_t e0, e1, ef, eo;
    @(negedge clk);
    set_req(1'b0, 8'h21, 8'h43, 1'b0);
    set_req(1'b1, 8'h80, 8'h80, 1'b1);
    e0 = model(1'b0, 8'h21, 8'h43, 1'b0);
    e1 = model(1'b1, 8'h80, 8'h80, 1'b1);
    ef = first ? e1 : e0;
    eo = first ? e0 : e1;
    sb.push_back(ef);
    sb.push_back(eo);
    wait_ack(first);
    check("rr_other_low", {31'b0, (first ? bus.ack0 : bus.ack1)}, 32'd0);
    @(negedge clk);
    drop(first);
    wait_ack(~first);
    last_exp = ef;
    @(negedge clk);
    drop(~first);
    wait_result(eo, 1'b1);
    check("sb_drain", sb.size(), 32'd0);
  endtask

  // Scoreboard side: every accepted result is popped and compared in order.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (bus.ack0 || bus.ack1) check("ack_overlap", {31'b0, bus.ack0 & bus.ack1}, 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", {31'b0, bus.out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_sum", {24'b0, bus.out_sum}, {24'b0, e.sum});
          check("out_carry", {31'b0, bus.out_carry}, {31'b0, e.carry});
          check("out_id", {31'b0, bus.out_id}, {31'b0, e.id});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ea, eb;
    bus.req0 = 1'b1; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.cin0 = 1'b0; bus.cin1 = 1'b0;
    bus.out_ready = 1'b1;
    last_exp = '0;

    // Reset with a request pending: ack must stay low.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack0", {31'b0, bus.ack0}, 32'd0);
    check("rst_ack1", {31'b0, bus.ack1}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_sum", {24'b0, bus.out_sum}, 32'd0);
    check("rst_carry", {31'b0, bus.out_carry}, 32'd0);
    check("rst_id", {31'b0, bus.out_id}, 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests after reset: requester 0 first.
    both(1'b0);

    run_op(1'b0, 8'h5A, 8'h3C, 1'b0);
    run_op(1'b1, 8'hFF, 8'h01, 1'b0);
    run_op(1'b1, 8'h00, 8'h00, 1'b1);

    // Requester 0 went last, so a tie now goes to requester 1.
    run_op(1'b0, 8'h0F, 8'hF0, 1'b1);
    both(1'b1);

    // Back-pressure in DONE with a competing request present.
    bus.out_ready = 1'b0;
    @(negedge clk);
    set_req(1'b0, 8'h12, 8'h34, 1'b1);
    ea = model(1'b0, 8'h12, 8'h34, 1'b1);
    sb.push_back(ea);
    wait_ack(1'b0);
    @(negedge clk);
    drop(1'b0);
    wait_result(ea, 1'b0);
    @(negedge clk);
    set_req(1'b1, 8'hC3, 8'h4D, 1'b0);
    eb = model(1'b1, 8'hC3, 8'h4D, 1'b0);
    sb.push_back(eb);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      check("stall_sum", {24'b0, bus.out_sum}, {24'b0, ea.sum});
      check("stall_carry", {31'b0, bus.out_carry}, {31'b0, ea.carry});
      check("stall_id", {31'b0, bus.out_id}, {31'b0, ea.id});
      check("stall_ack1", {31'b0, bus.ack1}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("hs_ack1_low", {31'b0, bus.ack1}, 32'd0);
    @(negedge clk);
    #1;
    check("post_hs_valid", {31'b0, bus.out_valid}, 32'd0);
    check("post_hs_ack1", {31'b0, bus.ack1}, 32'd1);
    @(negedge clk);
    drop(1'b1);
    wait_result(eb, 1'b1);

    // Reset during the second RUN cycle abandons the operation.
    @(negedge clk);
    set_req(1'b0, 8'hAA, 8'h55, 1'b0);
    sb.push_back(model(1'b0, 8'hAA, 8'h55, 1'b0));
    wait_ack(1'b0);
    @(negedge clk);
    drop(1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_busy", {31'b0, bus.busy}, 32'd0);
    check("midrun_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrun_ack", {30'b0, bus.ack1, bus.ack0}, 32'd0);
    check("midrun_sum", {24'b0, bus.out_sum}, 32'd0);
    check("midrun_carry", {31'b0, bus.out_carry}, 32'd0);
    check("midrun_id", {31'b0, bus.out_id}, 32'd0);
    sb.delete();
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("no_valid_after_rst", {31'b0, bus.out_valid}, 32'd0);
    end
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; even, >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports req0, req1  input  1 each  requester 0/1 request valid.
REQ-005 SHALL have ports a0, b0, a1, b1  input  WIDTH each  requester operands.
REQ-006 SHALL have ports cin0, cin1  input  1 each  requester carry-in.
REQ-007 SHALL have ports ack0, ack1  output  1 each  one-cycle acceptance pulse per requester.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  WIDTH  result sum.
REQ-012 SHALL have port out_carry  output  1  carry out of MSB.
REQ-013 SHALL have port out_id  output  1  requester that owns the result (0/1).

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on acceptance, RUN->DONE after last slice, DONE->IDLE on out_valid & out_ready.
REQ-015 SHALL, in IDLE with any req high, accept exactly one requester, pulse its ack for that cycle, and capture its a, b, cin.
REQ-016 SHALL arbitrate round-robin: if both req high, grant the requester not granted last; if one high, grant it.
REQ-017 SHALL ignore req0/req1 (ack low) in RUN and DONE; requesters hold request and operands until ack.
REQ-018 SHALL add 2 bits per cycle in RUN, LSB slice first, slice k using bits [2k+1:2k]; WIDTH/2 RUN cycles.
REQ-019 SHALL use captured cin as carry into slice 0 and register each slice carry-out as carry into the next slice.
REQ-020 SHALL set out_carry to carry out of the final slice; out_sum = (a + b + cin) mod 2^WIDTH.
REQ-021 SHALL have latency: ack in cycle T, out_valid high from cycle T+WIDTH/2+1 (T+5 for WIDTH=8).
REQ-022 SHALL hold out_valid, out_sum, out_carry, out_id stable in DONE while out_ready is low.
REQ-023 SHALL drop out_valid the cycle after handshake; next acceptance no earlier than the following cycle (no IDLE bypass).
REQ-024 SHALL keep out_sum/out_carry at previous values outside DONE; only out_valid qualifies them.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE; ack0, ack1, busy, out_valid, out_sum, out_carry, out_id all 0.
REQ-026 SHALL reset round-robin pointer so requester 0 wins the first simultaneous request.
REQ-027 SHALL abandon any in-flight operation on reset mid-RUN or mid-DONE; no result is produced for it.

Structure
REQ-028 SHALL place state enum (IDLE, RUN, DONE) and constant SLICE_W = 2 in shared package serial_add_pkg.
REQ-029 SHALL instantiate one sub-module add2_slice (2-bit operands, carry-in, 2-bit sum, carry-out, combinational) as the sole adder.
REQ-030 SHALL keep slice counter width clog2(WIDTH/2), minimum 1 bit.

Verification
REQ-031 SHALL cover: req0, a0=0x5A, b0=0x3C, cin0=0 -> ack0 at T, out_valid at T+5, out_sum=0x96, out_carry=0, out_id=0.
REQ-032 SHALL cover: req1, a1=0xFF, b1=0x01, cin1=0 -> out_sum=0x00, out_carry=1, out_id=1.
REQ-033 SHALL cover: req1, a1=0x00, b1=0x00, cin1=1 -> out_sum=0x01, out_carry=0.
REQ-034 SHALL cover: req0 and req1 high together after reset, out_ready=1 -> req0 served first, req1 second, ack pulses never overlap.
REQ-035 SHALL cover: out_ready held low 3 cycles in DONE -> out_valid and result unchanged, req ignored, then single handshake.
REQ-036 SHALL cover: rst_n asserted in second RUN cycle -> all outputs 0 at once, IDLE, no out_valid after release.
